fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e     : arbiter FSM state encoding (idle = 0, transfer = 1)
//   beat_cnt_width  : width needed to count 0..max_burst beats
//   ptr_width       : width of a requester index (at least 1 bit)
package fifo_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StXfer = 1'b1
  } arb_state_e;

  function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search.
//   REQ        : request vector
//   LAST_PTR   : index of the previous owner; the search starts one above it
//   NEXT_GRANT : one-hot winner, zero when REQ is zero
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [PTR_W-1:0]   LAST_PTR,
  output logic [NUM_REQ-1:0] NEXT_GRANT
);

  always_comb begin
    logic        found;
    int unsigned idx;
    NEXT_GRANT = '0;
    found      = 1'b0;
    idx        = 0;
    // Offsets 1..NUM_REQ visit every index once, ending on LAST_PTR itself.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(LAST_PTR) + off) % NUM_REQ;
      if (!found && REQ[idx]) begin
        NEXT_GRANT[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts until the accepted last word of a packet, MAX_BURST accepted
// words, or the owner dropping its request; FULL stalls the burst in place.
//   CLK, RST   : write clock, synchronous active-high reset
//   REQ        : per-requester word valid
//   REQ_DATA   : requester i word in [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_LAST   : per-requester last-word-of-packet flag
//   FULL       : FIFO full flag
//   ACK        : per-requester word accepted this cycle
//   GRANT      : one-hot current owner, zero when idle
//   W_INC      : FIFO write increment
//   WR_DATA    : FIFO write data, zero when idle
//   BUSY       : high while a burst is in progress
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]              REQ_LAST,
  input  logic                            FULL,
  output logic [NUM_REQ-1:0]              ACK,
  output logic [NUM_REQ-1:0]              GRANT,
  output logic                            W_INC,
  output logic [DATA_WIDTH-1:0]           WR_DATA,
  output logic                            BUSY
);

  localparam int unsigned PtrW  = ptr_width(NUM_REQ);
  localparam int unsigned BeatW = beat_cnt_width(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0]    gidx_q, gidx_d;
  logic [PtrW-1:0]    last_ptr_q, last_ptr_d;
  logic [BeatW-1:0]   beat_q, beat_d;

  logic [NUM_REQ-1:0] next_grant;
  logic [PtrW-1:0]    pick_idx;
  logic               req_g;
  logic               last_g;
  logic               accept;
  logic               burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_pick (
    .REQ        (REQ),
    .LAST_PTR   (last_ptr_q),
    .NEXT_GRANT (next_grant)
  );

  // Binary index of the round-robin winner, kept alongside the one-hot grant.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (next_grant[i]) pick_idx = PtrW'(i);
    end
  end

  assign req_g     = REQ[gidx_q];
  assign last_g    = REQ_LAST[gidx_q];
  assign accept    = (state_q == StXfer) && req_g && !FULL;
  // A stalled last word does not end the burst; only an accepted one does.
  assign burst_end = !req_g ||
                     (accept && (last_g || (32'(beat_q) + 32'd1 == MAX_BURST)));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_ptr_q <= PtrW'(NUM_REQ - 1);
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_ptr_q <= last_ptr_d;
      beat_q     <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_ptr_d = last_ptr_q;
    beat_d     = beat_q;
    unique case (state_q)
      StIdle: begin
        if (|REQ) begin
          state_d = StXfer;
          grant_d = next_grant;
          gidx_d  = pick_idx;
          beat_d  = '0;
        end
      end
      StXfer: begin
        if (accept) beat_d = beat_q + BeatW'(1);
        if (burst_end) begin
          state_d    = StIdle;
          grant_d    = '0;
          last_ptr_d = gidx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; the reset cycle itself must not push a word into the FIFO.
  always_comb begin
    W_INC        = accept && !RST;
    ACK          = '0;
    ACK[gidx_q]  = W_INC;
    GRANT        = grant_q;
    BUSY         = (state_q == StXfer);
    WR_DATA      = BUSY ? REQ_DATA[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a per-cycle reference model plus
// directed scenarios with hand-computed grant orders and write timings.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_LAST;
  logic            FULL;
  logic [N-1:0]    ACK;
  logic [N-1:0]    GRANT;
  logic            W_INC;
  logic [DW-1:0]   WR_DATA;
  logic            BUSY;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_DATA (REQ_DATA),
    .REQ_LAST (REQ_LAST),
    .FULL     (FULL),
    .ACK      (ACK),
    .GRANT    (GRANT),
    .W_INC    (W_INC),
    .WR_DATA  (WR_DATA),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus: per-requester packet sources ----------------
  int rem[N];   // words still to send
  int sent[N];  // words accepted so far
  int pkt[N];   // packet length (0: only the final word is marked last)
  bit drop[N];  // force REQ low (abandon)

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ[i]      = (rem[i] > 0) && !drop[i];
      REQ_LAST[i] = (rem[i] == 1) || (pkt[i] > 0 && ((sent[i] + 1) % pkt[i]) == 0);
      REQ_DATA[i*DW +: DW] = DW'(i * 64 + sent[i]);
    end
  endtask

  task automatic tick();
    logic [N-1:0] a;
    @(negedge CLK);
    a = ACK;
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (a[i]) begin
        rem[i]--;
        sent[i]++;
      end
    end
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rem[i] > 0 && !drop[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while ((pending() || BUSY) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_in_budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_sent(input int idx, input int target, input string name);
    int n = 0;
    while (sent[idx] < target && n < 20) begin
      tick();
      n++;
    end
    check({name, "_wait"}, 64'(sent[idx]), 64'(target));
  endtask

  // ---------------- reference model (rules applied per clock edge) --------
  int m_owner = -1;  // current owner, -1 when idle
  int m_words = 0;   // words accepted in the current burst
  int m_last  = N - 1;

  always @(posedge CLK) begin
    bit acc;
    bit found;
    int c;
    if (RST) begin
      m_owner = -1;
      m_words = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && REQ[c]) begin
          m_owner = c;
          found   = 1'b1;
        end
      end
      m_words = 0;
    end else begin
      acc = REQ[m_owner] && !FULL;
      if (acc) m_words++;
      if (!REQ[m_owner] || (acc && (REQ_LAST[m_owner] || m_words == MB))) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  // ---------------- compare process + observation log ---------------------
  int           gl[$];      // granted indices in order
  int           gl_cyc[$];  // cycle each grant appeared
  int           wl[$];      // cycles with W_INC
  logic [N-1:0] gprev = '0;

  always @(negedge CLK) begin
    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_ack;
    logic          e_winc;
    logic [DW-1:0] e_data;
    if (chk_en) begin
      e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_winc  = (m_owner >= 0) && REQ[m_owner] && !FULL && !RST;
      e_ack   = e_winc ? e_grant : '0;
      e_data  = (m_owner >= 0) ? REQ_DATA[m_owner*DW +: DW] : '0;
      check("grant", 64'(GRANT), 64'(e_grant));
      check("w_inc", 64'(W_INC), 64'(e_winc));
      check("ack", 64'(ACK), 64'(e_ack));
      check("wr_data", 64'(WR_DATA), 64'(e_data));
      check("busy", 64'(BUSY), 64'(m_owner >= 0));
      check("grant_onehot0", 64'($onehot0(GRANT)), 64'd1);
    end
    if (GRANT != '0 && gprev == '0) begin
      for (int i = 0; i < N; i++) begin
        if (GRANT[i]) begin
          gl.push_back(i);
          gl_cyc.push_back(cyc);
        end
      end
    end
    if (W_INC === 1'b1) wl.push_back(cyc);
    gprev = GRANT;
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    gl.delete();
    gl_cyc.delete();
    wl.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive();
    tick();
    RST = 1'b0;
    drive();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int rq;
    int s0;
    RST  = 1'b1;
    FULL = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
      pkt[i]  = 0;
      drop[i] = 1'b0;
    end
    drive();
    tick();
    chk_en = 1'b1;
    tick();
    RST = 1'b0;
    drive();
    check("reset_grant", 64'(GRANT), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_wr_data", 64'(WR_DATA), 64'd0);

    // Single 3-word burst from requester 0.
    clear_logs();
    rem[0] = 3;
    drive();
    rq = cyc;
    run_until_idle("single", 20);
    check("single_grant_cnt", 64'(gl.size()), 64'd1);
    check("single_grant_idx", 64'(qget(gl, 0)), 64'd0);
    check("single_grant_latency", 64'(qget(gl_cyc, 0) - rq), 64'd1);
    check("single_writes", 64'(wl.size()), 64'd3);
    check("single_first_write", 64'(qget(wl, 0) - qget(gl_cyc, 0)), 64'd0);
    check("single_consecutive", 64'(qget(wl, 2) - qget(wl, 0)), 64'd2);

    // Burst limit: 6 words, no last until the 6th -> bursts of 4 then 2.
    clear_logs();
    rem[1] = 6;
    drive();
    run_until_idle("limit", 30);
    check("limit_grant_cnt", 64'(gl.size()), 64'd2);
    check("limit_regrant_idx", 64'(qget(gl, 1)), 64'd1);
    check("limit_regrant_gap", 64'(qget(gl_cyc, 1) - qget(gl_cyc, 0)), 64'd5);
    check("limit_writes", 64'(wl.size()), 64'd6);
    check("limit_4th_write", 64'(qget(wl, 3) - qget(gl_cyc, 0)), 64'd3);

    // Round robin from reset with 1-word packets.
    do_reset();
    clear_logs();
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    for (int i = 0; i < N; i++) pkt[i] = 1;
    drive();
    run_until_idle("rr", 30);
    check("rr_grant_cnt", 64'(gl.size()), 64'd5);
    check("rr_g0", 64'(qget(gl, 0)), 64'd0);
    check("rr_g1", 64'(qget(gl, 1)), 64'd1);
    check("rr_g2", 64'(qget(gl, 2)), 64'd2);
    check("rr_g3", 64'(qget(gl, 3)), 64'd3);
    check("rr_g4", 64'(qget(gl, 4)), 64'd0);
    for (int i = 1; i < 5; i++) check("rr_bubble", 64'(qget(gl_cyc, i) - qget(gl_cyc, i - 1)), 64'd2);

    // FULL stall of 5 cycles on the 2nd (and last) beat.
    clear_logs();
    for (int i = 0; i < N; i++) pkt[i] = 0;
    s0 = sent[1];
    rem[1] = 2;
    drive();
    wait_sent(1, s0 + 1, "stall");
    FULL = 1'b1;
    drive();
    repeat (5) tick();
    FULL = 1'b0;
    drive();
    run_until_idle("stall", 20);
    check("stall_grant_cnt", 64'(gl.size()), 64'd1);
    check("stall_grant_idx", 64'(qget(gl, 0)), 64'd1);
    check("stall_writes", 64'(wl.size()), 64'd2);
    check("stall_gap", 64'(qget(wl, 1) - qget(wl, 0)), 64'd6);

    // Abandon: requester 2 drops after one word; the next grant goes to 3.
    clear_logs();
    s0 = sent[2];
    rem[2] = 5;
    drive();
    wait_sent(2, s0 + 1, "abandon");
    drop[2] = 1'b1;
    drive();
    tick();
    check("abandon_idle", 64'(BUSY), 64'd0);
    tick();
    drop[2] = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 1;
      pkt[i] = 1;
    end
    drive();
    run_until_idle("abandon", 30);
    check("abandon_first", 64'(qget(gl, 0)), 64'd2);
    check("abandon_next", 64'(qget(gl, 1)), 64'd3);
    check("abandon_then", 64'(qget(gl, 2)), 64'd0);
    check("abandon_words2", 64'(sent[2] - s0), 64'd2);

    // Reset during the 2nd beat of requester 1's burst.
    clear_logs();
    for (int i = 0; i < N; i++) pkt[i] = 0;
    s0 = sent[1];
    rem[1] = 4;
    drive();
    wait_sent(1, s0 + 1, "rstmid");
    RST = 1'b1;
    rem[0] = 1;
    drive();
    tick();
    RST = 1'b0;
    drive();
    check("rstmid_grant", 64'(GRANT), 64'd0);
    check("rstmid_w_inc", 64'(W_INC), 64'd0);
    check("rstmid_words", 64'(sent[1] - s0), 64'd1);
    run_until_idle("rstmid", 30);
    check("rstmid_pre_owner", 64'(qget(gl, 0)), 64'd1);
    check("rstmid_post_first", 64'(qget(gl, 1)), 64'd0);
    check("rstmid_post_second", 64'(qget(gl, 2)), 64'd1);
    check("rstmid_total", 64'(sent[1] - s0), 64'd4);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
